// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory response block: FSM state encoding,
// bus widths and a small address helper.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // A byte address is misaligned for a word access when its low two bits are set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Pipeline-to-data-memory bus: request/store signals from the EXE/MEM stage,
// load data, status pulses and the stall back to the pipeline.
interface data_mem_resp_if;
  import dmem_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              pause;
  logic              misalign;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid, pause, misalign
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid, pause, misalign
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, DEPTH x 32. The read register only updates
// on a read strobe, so it doubles as the held load-data output. Storage itself
// is never cleared by reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: loads on a read strobe, otherwise holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory response controller: accepts one load/store at a time from the
// pipeline, stalls it for LAT cycles, then completes in a one-cycle DONE state.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject non-word-aligned
// requests (straight to DONE, no RAM access, misalign pulse).
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              mis_q, mis_d;

  logic              pause_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [AW-1:0]     ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic [AW-1:0]     idx_in_s;
  logic              req_mis_s;
  logic              unused_addr_s;

  // Word index wraps modulo DEPTH: only the bits just above the byte offset count.
  assign idx_in_s = bus.mem_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign req_mis_s     = is_misaligned(bus.mem_addr[1:0]);
  assign unused_addr_s = ^bus.mem_addr[ADDR_W-1:AW+2];
`else
  assign req_mis_s     = 1'b0;
  assign unused_addr_s = ^{bus.mem_addr[ADDR_W-1:AW+2], bus.mem_addr[1:0]};
`endif

  // Next-state, counter, capture and RAM strobe logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rvalid_d    = 1'b0;
    mis_d       = 1'b0;
    pause_s     = 1'b0;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_addr_s  = idx_q;
    ram_wdata_s = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          pause_s = 1'b1;
          we_d    = bus.mem_we;
          idx_d   = idx_in_s;
          wdata_d = bus.mem_wdata;
          if (req_mis_s) begin
            state_d = DONE;
            cnt_d   = {CNT_W{1'b0}};
            mis_d   = 1'b1;
          end else if (LAT == 1) begin
            // Single-cycle latency: the access happens on the accepting edge,
            // so it uses the live inputs rather than the captured copy.
            state_d     = DONE;
            cnt_d       = {CNT_W{1'b0}};
            ram_addr_s  = idx_in_s;
            ram_wdata_s = bus.mem_wdata;
            ram_we_s    = bus.mem_we;
            ram_re_s    = ~bus.mem_we;
            rvalid_d    = ~bus.mem_we;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LAT - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        pause_s = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = DONE;
          cnt_d    = {CNT_W{1'b0}};
          ram_we_s = we_q;
          ram_re_s = ~we_q;
          rvalid_d = ~we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, captured request and status pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      we_q     <= 1'b0;
      idx_q    <= {AW{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we_s & ~rst),
    .re_i    (ram_re_s & ~rst),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // The stall is combinational so the pipeline freezes in the request cycle;
  // it is suppressed while reset is held.
  assign bus.pause      = pause_s & ~rst;
  assign bus.mem_rdata  = ram_rdata_s;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.misalign   = mis_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (DEPTH=1024, LAT=2): a table of
// directed load/store transactions plus hand-written reset, misalignment and
// back-to-back sequences.
module tb_data_mem_resp;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  data_mem_resp_if bus ();

  data_mem_resp #(
    .DEPTH (1024),
    .LAT   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One LAT=2 transaction with per-cycle checks; inputs are scrambled mid-BUSY.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input string name);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    #1;
    chk({name, " pause c0"}, {31'd0, bus.pause}, 32'd1);
    tick();
    bus.mem_req   = 1'b0;
    bus.mem_we    = ~we;
    bus.mem_addr  = addr ^ 32'h0000_0004;
    bus.mem_wdata = ~wdata;
    #1;
    chk({name, " pause busy"}, {31'd0, bus.pause}, 32'd1);
    chk({name, " rvalid busy"}, {31'd0, bus.mem_rvalid}, 32'd0);
    tick();
    chk({name, " pause done"}, {31'd0, bus.pause}, 32'd0);
    chk({name, " rvalid done"}, {31'd0, bus.mem_rvalid}, we ? 32'd0 : 32'd1);
    chk({name, " rdata done"}, bus.mem_rdata, exp_rd);
    chk({name, " misalign"}, {31'd0, bus.misalign}, 32'd0);
    tick();
    chk({name, " rvalid idle"}, {31'd0, bus.mem_rvalid}, 32'd0);
    chk({name, " rdata hold"}, bus.mem_rdata, exp_rd);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, "wr10"};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, "rd10"};
    vecs[2] = '{1'b1, 32'h0000_1010, 32'h1234_5678, 32'hDEAD_BEEF, "wr1010"};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, "rd10wrap"};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h1234_5678, "wr20"};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1111_2222, "rd20"};
    vecs[6] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h1111_2222, "wrtop"};
    vecs[7] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, "rdtop"};
    vecs[8] = '{1'b0, 32'hFFFF_F010, 32'h0000_0000, 32'h1234_5678, "rdhigh"};

    // Reset with a request pending: nothing may stall or pulse.
    rst           = 1'b1;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0000_0000;
    bus.mem_wdata = 32'h0000_0000;
    tick();
    tick();
    chk("rst pause", {31'd0, bus.pause}, 32'd0);
    chk("rst rdata", bus.mem_rdata, 32'd0);
    chk("rst rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    chk("rst misalign", {31'd0, bus.misalign}, 32'd0);
    bus.mem_req = 1'b0;
    rst         = 1'b0;
    tick();
    chk("idle pause", {31'd0, bus.pause}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
    end

    // Reset during BUSY of a write: the write must not commit.
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0020;
    bus.mem_wdata = 32'hAAAA_5555;
    tick();
    chk("abort pause busy", {31'd0, bus.pause}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort pause rst", {31'd0, bus.pause}, 32'd0);
    chk("abort rdata rst", bus.mem_rdata, 32'd0);
    tick();
    tick();
    chk("abort rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    bus.mem_req = 1'b0;
    rst         = 1'b0;
    tick();
    run_txn(1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1111_2222, "rd20after");

    // Misaligned read of 0x13.
`ifdef DMEM_MISALIGN_CHECK_EN
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0000_0013;
    #1;
    chk("mis pause c0", {31'd0, bus.pause}, 32'd1);
    tick();
    bus.mem_req = 1'b0;
    #1;
    chk("mis misalign", {31'd0, bus.misalign}, 32'd1);
    chk("mis rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    chk("mis pause done", {31'd0, bus.pause}, 32'd0);
    chk("mis rdata", bus.mem_rdata, 32'h1111_2222);
    tick();
    chk("mis pulse end", {31'd0, bus.misalign}, 32'd0);
`else
    run_txn(1'b0, 32'h0000_0013, 32'h0000_0000, 32'h1234_5678, "rd13");
`endif

    // Back-to-back with mem_req held: write 0x30 then read 0x30.
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0030;
    bus.mem_wdata = 32'h55AA_55AA;
    #1;
    chk("b2b pause c0", {31'd0, bus.pause}, 32'd1);
    tick();
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'h0000_0000;
    #1;
    chk("b2b pause c1", {31'd0, bus.pause}, 32'd1);
    tick();
    chk("b2b pause done", {31'd0, bus.pause}, 32'd0);
    chk("b2b rvalid wr", {31'd0, bus.mem_rvalid}, 32'd0);
    tick();
    chk("b2b pause c3", {31'd0, bus.pause}, 32'd1);
    tick();
    bus.mem_req = 1'b0;
    #1;
    chk("b2b pause c4", {31'd0, bus.pause}, 32'd1);
    tick();
    chk("b2b rvalid rd", {31'd0, bus.mem_rvalid}, 32'd1);
    chk("b2b rdata", bus.mem_rdata, 32'h55AA_55AA);
    tick();
    chk("b2b rvalid end", {31'd0, bus.mem_rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LAT, default 2, access latency in cycles from request acceptance to completion (LAT >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  input  1  memory request from the EXE/MEM pipeline register.
REQ-006 SHALL have port mem_we  input  1  1 = write, 0 = read; sampled with mem_req.
REQ-007 SHALL have port mem_addr  input  32  byte address (ALU result).
REQ-008 SHALL have port mem_wdata  input  32  store data (register-2 value).
REQ-009 SHALL have port mem_rdata  output  32  registered load data.
REQ-010 SHALL have port mem_rvalid  output  1  one-cycle pulse: mem_rdata updated by a completed read.
REQ-011 SHALL have port pause  output  1  stall to the pipeline; upstream registers hold while high.
REQ-012 SHALL have port misalign  output  1  one-cycle pulse: misaligned request rejected.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE with mem_req=1 SHALL accept the request: capture mem_we, word index mem_addr[log2(DEPTH)+1:2] and mem_wdata; load latency counter with LAT-1; go to BUSY (or directly to DONE when LAT=1).
REQ-015 BUSY SHALL decrement the counter each cycle and go to DONE on the cycle the counter reaches 0.
REQ-016 DONE SHALL go to IDLE unconditionally; mem_req during DONE SHALL be ignored.
REQ-017 pause SHALL be combinational: high when (IDLE and mem_req) or BUSY; low in DONE and in IDLE without a request.
REQ-018 A write SHALL commit to RAM on the clock edge entering DONE; mem_rdata unchanged; mem_rvalid stays 0.
REQ-019 A read SHALL load mem_rdata on the edge entering DONE; mem_rvalid high exactly during DONE.
REQ-020 mem_rdata SHALL hold its last value until the next completed read.
REQ-021 Total request-to-DONE latency SHALL be exactly LAT cycles; pause is high for LAT cycles per request.
REQ-022 Word index SHALL wrap modulo DEPTH; upper address bits are ignored.
REQ-023 Inputs captured at acceptance SHALL be used for the whole transaction; later input changes are ignored.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, counter 0, mem_rdata 0, mem_rvalid 0, misalign 0.
REQ-025 Reset mid-transaction SHALL abort it with no RAM write committed; RAM contents are not cleared.
REQ-026 pause SHALL be 0 during reset regardless of mem_req.

Configuration
REQ-027 With DMEM_MISALIGN_CHECK_EN defined, a request with mem_addr[1:0] != 0 SHALL go straight to DONE, perform no RAM access, pulse misalign in DONE, and leave mem_rvalid 0.
REQ-028 Without DMEM_MISALIGN_CHECK_EN, mem_addr[1:0] SHALL be ignored and misalign tied to 0.

Structure
REQ-029 State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the 32-bit data width constant SHALL live in shared package dmem_pkg.
REQ-030 RAM storage SHALL be a sub-module dmem_ram: single-port synchronous, write enable, DEPTH x 32.

Verification
REQ-031 Reset then write 0xDEADBEEF to 0x0000_0010, LAT=2 -> pause high 2 cycles, rvalid 0, mem_rdata stays 0.
REQ-032 Read 0x0000_0010 after REQ-031 -> mem_rdata=0xDEADBEEF in DONE, rvalid pulses exactly 1 cycle, 2 cycles after request.
REQ-033 Write 0x12345678 to word 0x0000_1010 (DEPTH=1024), then read 0x0000_0010 -> 0x12345678 (wrap).
REQ-034 Assert rst during BUSY of a write of 0xAAAA5555 to 0x20, then read 0x20 -> old value returned, no commit.
REQ-035 With macro defined, read 0x0000_0013 -> misalign 1 for one cycle, rvalid 0, pause high 1 cycle; without macro -> normal read of word 4.
REQ-036 Back-to-back requests held on mem_req -> second accepted in IDLE after DONE; inputs changed mid-BUSY ignored.
